multi_byte_uart_tx: RTL and testbench
=====================================

# multi_byte_uart_tx

Parametrised word-to-UART transmitter. It accepts a word of `BYTES` bytes through a valid/ready handshake and serialises it as consecutive 8N1/8N2 UART frames on `tx`. The byte order, stop-bit count, inter-byte idle gap and baud divisor are all configurable. It contains its own bit-level serialiser, replaces the fixed 32-bit word sender, and sits between the core's debug/trace logic and the board UART pin.

## Interface
Parameters:
- `BYTES`, 4, bytes per word; must be ≥1.
- `CLKS_PER_BIT`, 868, clock cycles per UART bit; must be ≥2.
- `MSB_FIRST`, 0, byte order. 0 sends byte 0 (`[7:0]`) first; 1 sends the top byte first. Bits inside a byte are always LSB-first.
- `STOP_BITS`, 1, stop bits per frame; allowed values are 1 and 2.
- `GAP_BITS`, 0, idle-high bit times inserted between bytes of one word. No gap is inserted after the last byte.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `word_valid`  in  1  a word is offered on `word_data`.
- `word_data`  in  8*BYTES  word to send; sampled only at acceptance.
- `word_ready`  out  1  block can accept a word.
- `tx`  out  1  UART line, registered, idle high.
- `busy`  out  1  a word is in flight.
- `word_send`  out  1  one-cycle pulse when the last stop bit of a word completes.

## Operation
- States:
  - `IDLE`: `word_ready`=1.
  - `START`: `tx`=0.
  - `DATA`: 8 bits, index 0..7.
  - `STOP`: `tx`=1 for STOP_BITS bit times.
  - `GAP`: `tx`=1 for GAP_BITS bit times; skipped when GAP_BITS=0.
- Acceptance occurs when `word_valid` && `word_ready` at a clock edge. On that edge:
  - `word_data` is copied into an internal shift register;
  - the byte counter is cleared;
  - the state moves to `START`.
- Later changes on `word_data` or `word_valid` have no effect until the next acceptance.
- Baud counter: counts 0..CLKS_PER_BIT-1, and each bit lasts exactly CLKS_PER_BIT cycles. The counter clears on every state change.
- After `STOP`:
  - If more bytes remain, go to `GAP` (or directly to `START` when GAP_BITS=0), then `START`.
  - After the last byte, go to `IDLE` and pulse `word_send`.
- Byte selection: byte k is `word_data[8k+7:8k]`, where k counts up from 0 when MSB_FIRST=0 and down from BYTES-1 when MSB_FIRST=1.
- Byte counter width is max(1, clog2(BYTES)); the last byte is counter == BYTES-1. The counter does not wrap during a word.
- `busy` = (state != IDLE).
- `word_ready` = (state == IDLE) && reset deasserted.
- Reset low:
  - While low: `tx`=1, `busy`=0, `word_send`=0, `word_ready`=0. The state goes to `IDLE` and all counters clear.
  - Mid-frame reset aborts the word: `tx` returns high on the next edge and no `word_send` is issued.
- Illegal parameter values (BYTES<1, CLKS_PER_BIT<2, STOP_BITS∉{1,2}) trigger an elaboration-time `$error`.

## Timing
- Accept at edge E0. `tx` goes low (start bit) from E0 and stays low for CLKS_PER_BIT cycles.
- Frame length per byte: F = CLKS_PER_BIT*(9+STOP_BITS).
- Word length: T = BYTES*F + (BYTES-1)*GAP_BITS*CLKS_PER_BIT cycles.
- End of word, at edge E0+T:
  - state returns to `IDLE`;
  - `word_send`=1 for exactly that one cycle;
  - `word_ready`=1 and `busy`=0 in that same cycle.
- Back-to-back: if `word_valid` is high in the `word_send` cycle, the next word is accepted at the next edge. `tx` then goes low one cycle after the last stop bit ends; there is no extra idle time.
- Reset deasserted at edge R: `word_ready`=1 from R onwards. The earliest acceptance is at edge R+1.

## Test plan
- BYTES=4, CLKS_PER_BIT=4, MSB_FIRST=0, STOP_BITS=1, `word_data`=0xA1B2C3D4:
  - the decoded bytes are D4, C3, B2, A1;
  - `word_send` pulses exactly 160 cycles after acceptance;
  - `busy` is high for 160 cycles.
- Same setup with MSB_FIRST=1: decoded bytes are A1, B2, C3, D4.
- STOP_BITS=2, GAP_BITS=2, CLKS_PER_BIT=4, BYTES=4, data 0x00FF55AA:
  - each stop period is high for 8 cycles;
  - each inter-byte gap is high for 8 cycles;
  - `word_send` is at 200 cycles.
- `word_valid` held high with 0x11223344 then 0x55667788, with `word_data` toggled randomly while `busy` is high:
  - both words are decoded exactly;
  - the second start bit begins the cycle after `word_send`;
  - `word_send` pulses exactly twice.
- Reset low during bit 3 of byte 1:
  - `tx`=1 on the next edge;
  - no `word_send`;
  - `word_ready`=1 after release;
  - a fresh word 0xDEADBEEF is then sent correctly.
- BYTES=1, CLKS_PER_BIT=2, data 0x5A:
  - a single frame `0 0 1 0 1 1 0 1 0 1` (start, data LSB-first, stop) is observed;
  - `word_send` is at 20 cycles.

Source files
------------

// File: rtl/multi_byte_uart_tx.sv
// -----------------------------------------------------------------------------
// multi_byte_uart_tx
//
// Accepts a word of BYTES bytes over a valid/ready handshake and sends it as
// back-to-back UART frames (1 start bit, 8 data bits LSB-first, 1 or 2 stop
// bits) on a registered, idle-high tx line. An optional idle gap of GAP_BITS
// bit times separates the bytes of one word. The baud divisor, byte order,
// stop-bit count and gap length are parameters.
//
// Parameters:
//   BYTES        bytes per word (>= 1)
//   CLKS_PER_BIT clock cycles per UART bit (>= 2)
//   MSB_FIRST    0: byte [7:0] goes first, 1: top byte goes first
//   STOP_BITS    stop bits per frame (1 or 2)
//   GAP_BITS     idle bit times between bytes of one word (none after last)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   word_valid in   a word is offered on word_data
//   word_data  in   word to send, sampled only on the accepting edge
//   word_ready out  block can accept a word this cycle
//   tx         out  UART line, registered, idle high
//   busy       out  a word is in flight (state != IDLE)
//   word_send  out  one-cycle pulse as the last stop bit of a word completes
//   fsm_state  out  current FSM state encoding (IDLE=0 START=1 DATA=2
//                   STOP=3 GAP=4), for observation only
//
// Handshake: a word transfers on a rising edge where word_valid and word_ready
// are both high. word_ready does not depend on word_valid. Once a word is
// taken, word_valid/word_data are ignored until the block is back in IDLE.
// -----------------------------------------------------------------------------
module multi_byte_uart_tx #(
    parameter int BYTES        = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int MSB_FIRST    = 0,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 word_valid,
    input  logic [8*BYTES-1:0]   word_data,
    output logic                 word_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 word_send,
    output logic [2:0]           fsm_state
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (BYTES < 1) begin : g_bad_bytes
        $error("multi_byte_uart_tx: BYTES must be >= 1");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("multi_byte_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("multi_byte_uart_tx: STOP_BITS must be 1 or 2");
    end

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int W        = 8 * BYTES;
    localparam int BAUD_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    // One bit counter serves DATA (0..7), STOP and GAP, so it must hold the
    // larger of 7 and GAP_BITS-1.
    localparam int MAX_BITS = (GAP_BITS > 8) ? GAP_BITS : 8;
    localparam int BIT_W    = $clog2(MAX_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(7);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  GAP_LAST  = (GAP_BITS > 0) ? BIT_W'(GAP_BITS - 1) : '0;
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q,  baud_d;
    logic [BIT_W-1:0]    bit_q,   bit_d;
    logic [BYTE_W-1:0]   byte_q,  byte_d;
    logic [W-1:0]        word_q,  word_d;
    logic                tx_d;
    logic                send_d;
    logic                ready_en_q;

    logic                bit_done;
    logic [7:0]          cur_byte;

    assign bit_done = (baud_q == BAUD_LAST);

    // The byte being sent always sits at the "outgoing" end of word_q; the
    // register is shifted by one byte each time a byte's frame finishes.
    assign cur_byte = (MSB_FIRST != 0) ? word_q[W-1 -: 8] : word_q[7:0];

    // ready_en_q rises on the first edge that samples reset high, so a word
    // can be taken no earlier than the edge after reset release. The direct
    // reset term drops word_ready as soon as reset is asserted.
    assign word_ready = (state_q == IDLE) && reset && ready_en_q;
    assign busy       = (state_q != IDLE);
    assign fsm_state  = state_q;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        word_d  = word_q;
        send_d  = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (word_valid && word_ready) begin
                    state_d = START;
                    word_d  = word_data;
                    byte_d  = '0;
                end
            end

            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                if (bit_done) begin
                    if (bit_q == DATA_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end

            STOP: begin
                if (bit_done) begin
                    if (bit_q == STOP_LAST) begin
                        if (byte_q == BYTE_LAST) begin
                            state_d = IDLE;
                            send_d  = 1'b1;
                        end else begin
                            byte_d  = byte_q + BYTE_W'(1);
                            word_d  = (MSB_FIRST != 0) ? (word_q << 8) : (word_q >> 8);
                            state_d = (GAP_BITS > 0) ? GAP : START;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end

            GAP: begin
                if (bit_done) begin
                    if (bit_q == GAP_LAST) begin
                        state_d = START;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Both counters restart on any state change; the baud counter also
        // wraps at the end of every bit inside a multi-bit state.
        if (state_d != state_q) begin
            baud_d = '0;
            bit_d  = '0;
        end else if (bit_done) begin
            baud_d = '0;
        end

        // tx is registered, so it is computed from the state being entered:
        // the line changes on the same edge as the state does.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d[2:0]];
            default: tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            word_q     <= '0;
            tx         <= 1'b1;
            word_send  <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            word_q     <= word_d;
            tx         <= tx_d;
            word_send  <= send_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_byte_uart_tx.sv
// -----------------------------------------------------------------------------
// Testbench for multi_byte_uart_tx.
// Four instances cover the parameter sets of interest:
//   0: BYTES=4 CLKS=4 LSB-first STOP=1 GAP=0
//   1: BYTES=4 CLKS=4 MSB-first STOP=1 GAP=0
//   2: BYTES=4 CLKS=4 LSB-first STOP=2 GAP=2
//   3: BYTES=1 CLKS=2 STOP=1
// tx is recorded every cycle after acceptance, compared against a timing
// model, and decoded into bytes that are compared against a vector table.
// -----------------------------------------------------------------------------
module tb_multi_byte_uart_tx;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [3:0]  valid_v = '0;
    logic [31:0] data_v [4];
    logic [3:0]  tx_w, busy_w, ready_w, send_w;
    logic [2:0]  st_w [4];

    // parameter mirror used by the timing model / decoder
    int nb_p   [4] = '{4, 4, 4, 1};
    int cpb_p  [4] = '{4, 4, 4, 2};
    int msb_p  [4] = '{0, 1, 0, 0};
    int stop_p [4] = '{1, 1, 2, 1};
    int gap_p  [4] = '{0, 0, 2, 0};

    multi_byte_uart_tx #(.BYTES(4), .CLKS_PER_BIT(4), .MSB_FIRST(0), .STOP_BITS(1), .GAP_BITS(0)) u_a (
        .clk(clk), .reset(reset), .word_valid(valid_v[0]), .word_data(data_v[0]),
        .word_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .word_send(send_w[0]), .fsm_state(st_w[0]));
    multi_byte_uart_tx #(.BYTES(4), .CLKS_PER_BIT(4), .MSB_FIRST(1), .STOP_BITS(1), .GAP_BITS(0)) u_b (
        .clk(clk), .reset(reset), .word_valid(valid_v[1]), .word_data(data_v[1]),
        .word_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .word_send(send_w[1]), .fsm_state(st_w[1]));
    multi_byte_uart_tx #(.BYTES(4), .CLKS_PER_BIT(4), .MSB_FIRST(0), .STOP_BITS(2), .GAP_BITS(2)) u_c (
        .clk(clk), .reset(reset), .word_valid(valid_v[2]), .word_data(data_v[2]),
        .word_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .word_send(send_w[2]), .fsm_state(st_w[2]));
    multi_byte_uart_tx #(.BYTES(1), .CLKS_PER_BIT(2), .MSB_FIRST(0), .STOP_BITS(1), .GAP_BITS(0)) u_d (
        .clk(clk), .reset(reset), .word_valid(valid_v[3]), .word_data(data_v[3][7:0]),
        .word_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .word_send(send_w[3]), .fsm_state(st_w[3]));

    // ---------------- scoreboard state ----------------
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic rec [0:511];

    typedef struct {
        int          sel;
        logic [31:0] data;
        logic [31:0] exp_seq;   // byte b in send order at [8b+7:8b]
        int          exp_len;   // cycles from acceptance to word_send
        string       name;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected tx level t cycles after the accepting edge.
    function automatic logic exp_tx(input int sel, input logic [31:0] d, input int t);
        int c, nb, f, per, tot, b, off, k;
        c   = cpb_p[sel];
        nb  = nb_p[sel];
        f   = c * (9 + stop_p[sel]);
        per = f + gap_p[sel] * c;
        tot = nb * f + (nb - 1) * gap_p[sel] * c;
        if (t >= tot) return 1'b1;
        b   = t / per;
        off = t % per;
        if (off < c) return 1'b0;
        if (off >= 9 * c) return 1'b1;
        k = (msb_p[sel] != 0) ? (nb - 1 - b) : b;
        return d[8 * k + (off - c) / c];
    endfunction

    // Mid-bit sampling receiver over the recorded line.
    function automatic logic [7:0] decode_byte(input int sel, input int base, input int b);
        int c, per, s;
        logic [7:0] r;
        c   = cpb_p[sel];
        per = c * (9 + stop_p[sel]) + gap_p[sel] * c;
        s   = base + b * per;
        for (int j = 0; j < 8; j++) r[j] = rec[s + c + j * c + c / 2];
        return r;
    endfunction

    // ---------------- driver + monitor ----------------
    task automatic run_word(input int sel, input logic [31:0] d, input logic [31:0] exp_seq,
                            input int exp_len, input string nm);
        int w, wave_err, first_bad, busy_cnt, send_cnt, send_t;
        w = 0; wave_err = 0; first_bad = -1; busy_cnt = 0; send_cnt = 0; send_t = -1;
        @(negedge clk);
        while (!ready_w[sel] && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({nm, " ready"}, 64'(ready_w[sel]), 64'd1);
        if (!ready_w[sel]) return;
        valid_v[sel] = 1'b1;
        data_v[sel]  = d;
        @(posedge clk);                       // accepting edge E0
        for (int t = 0; t <= exp_len + 4; t++) begin
            @(negedge clk);
            if (t == 0) begin
                valid_v[sel] = 1'b0;
                data_v[sel]  = $urandom();
            end
            rec[t] = tx_w[sel];
            if (tx_w[sel] !== exp_tx(sel, d, t)) begin
                if (wave_err == 0) first_bad = t;
                wave_err++;
            end
            busy_cnt += int'(busy_w[sel]);
            if (send_w[sel]) begin
                send_cnt++;
                if (send_t < 0) send_t = t;
            end
        end
        check({nm, " tx_wave_errs"}, 64'(wave_err), 64'd0);
        if (wave_err != 0) $display("  first tx deviation at cycle %0d", first_bad);
        for (int b = 0; b < nb_p[sel]; b++)
            check($sformatf("%s byte%0d", nm, b), 64'(decode_byte(sel, 0, b)), 64'(exp_seq[8 * b +: 8]));
        check({nm, " send_cycle"}, 64'(send_t), 64'(exp_len));
        check({nm, " send_count"}, 64'(send_cnt), 64'd1);
        check({nm, " busy_cycles"}, 64'(busy_cnt), 64'(exp_len));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        logic [9:0]  frame;
        logic [15:0] ones;
        int          send_cnt, wave_err, t_send1, t_send2;

        vecs[0] = '{0, 32'hA1B2C3D4, 32'hA1B2C3D4, 160, "lsb_a1b2c3d4"};
        vecs[1] = '{1, 32'hA1B2C3D4, 32'hD4C3B2A1, 160, "msb_a1b2c3d4"};
        vecs[2] = '{2, 32'h00FF55AA, 32'h00FF55AA, 200, "gap_00ff55aa"};
        vecs[3] = '{3, 32'h0000005A, 32'h0000005A, 20,  "one_5a"};
        vecs[4] = '{0, 32'h00000000, 32'h00000000, 160, "lsb_zero"};
        vecs[5] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 160, "lsb_ones"};
        vecs[6] = '{1, 32'h80000001, 32'h01000080, 160, "msb_80000001"};
        vecs[7] = '{2, 32'h12345678, 32'h12345678, 200, "gap_12345678"};

        for (int i = 0; i < 4; i++) data_v[i] = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("reset tx", 64'(tx_w), 64'hF);
        check("reset busy", 64'(busy_w), 64'h0);
        check("reset ready", 64'(ready_w), 64'h0);
        check("reset send", 64'(send_w), 64'h0);
        check("reset state", 64'({st_w[0], st_w[1], st_w[2], st_w[3]}), 64'h0);
        reset = 1'b1;
        #1;
        check("ready before first edge", 64'(ready_w), 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("ready after release", 64'(ready_w), 64'hF);

        // ---- vector table ----
        for (int i = 0; i < 8; i++)
            run_word(vecs[i].sel, vecs[i].data, vecs[i].exp_seq, vecs[i].exp_len, vecs[i].name);

        // ---- single 8N1 frame, exact bit pattern ----
        run_word(3, 32'h5A, 32'h5A, 20, "frame_5a");
        for (int i = 0; i < 10; i++) frame[9 - i] = rec[2 * i + 1];
        check("frame_5a bits", 64'(frame), 64'(10'b0010110101));

        // ---- stop + gap periods are 8 high cycles each ----
        run_word(2, 32'h00FF55AA, 32'h00FF55AA, 200, "stopgap");
        for (int i = 0; i < 16; i++) ones[i] = rec[36 + i];
        check("stopgap byte0 stop+gap", 64'(ones), 64'hFFFF);
        check("stopgap byte1 start", 64'(rec[52]), 64'd0);
        for (int i = 0; i < 16; i++) ones[i] = rec[88 + i];
        check("stopgap byte1 stop+gap", 64'(ones), 64'hFFFF);
        check("stopgap byte2 start", 64'(rec[104]), 64'd0);

        // ---- back-to-back with valid held, data scrambled while busy ----
        send_cnt = 0; wave_err = 0; t_send1 = -1; t_send2 = -1;
        @(negedge clk);
        check("b2b ready", 64'(ready_w[0]), 64'd1);
        valid_v[0] = 1'b1;
        data_v[0]  = 32'h11223344;
        @(posedge clk);
        for (int t = 0; t <= 325; t++) begin
            @(negedge clk);
            rec[t] = tx_w[0];
            if (t <= 160) begin
                if (tx_w[0] !== exp_tx(0, 32'h11223344, t)) wave_err++;
            end else begin
                if (tx_w[0] !== exp_tx(0, 32'h55667788, t - 161)) wave_err++;
            end
            if (send_w[0]) begin
                send_cnt++;
                if (t_send1 < 0) t_send1 = t; else t_send2 = t;
                data_v[0] = 32'h55667788;
            end else if (busy_w[0]) begin
                data_v[0] = $urandom();
            end
            if (t == 161) valid_v[0] = 1'b0;
        end
        check("b2b tx_wave_errs", 64'(wave_err), 64'd0);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("b2b w1 byte%0d", b), 64'(decode_byte(0, 0, b)), 64'(8'h44 - 8'(b * 8'h11)));
            check($sformatf("b2b w2 byte%0d", b), 64'(decode_byte(0, 161, b)), 64'(8'h88 - 8'(b * 8'h11)));
        end
        check("b2b send_count", 64'(send_cnt), 64'd2);
        check("b2b send1 cycle", 64'(t_send1), 64'd160);
        check("b2b send2 cycle", 64'(t_send2), 64'd321);
        check("b2b idle in send cycle", 64'(rec[160]), 64'd1);
        check("b2b second start", 64'(rec[161]), 64'd0);

        // ---- reset during bit 3 of byte 1 ----
        @(negedge clk);
        valid_v[0] = 1'b1;
        data_v[0]  = 32'hCAFEF00D;
        @(posedge clk);
        for (int t = 0; t <= 57; t++) begin
            @(negedge clk);
            if (t == 0) valid_v[0] = 1'b0;
        end
        check("abort tx before reset", 64'(tx_w[0]), 64'd0);   // bit3 of 0xF0
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort tx", 64'(tx_w[0]), 64'd1);
        check("abort busy", 64'(busy_w[0]), 64'd0);
        check("abort ready", 64'(ready_w[0]), 64'd0);
        send_cnt = int'(send_w[0]);
        repeat (3) begin
            @(negedge clk);
            send_cnt += int'(send_w[0]);
        end
        reset = 1'b1;
        @(posedge clk);
        for (int t = 0; t < 120; t++) begin
            @(negedge clk);
            send_cnt += int'(send_w[0]);
        end
        check("abort no send", 64'(send_cnt), 64'd0);
        check("abort ready after release", 64'(ready_w[0]), 64'd1);
        run_word(0, 32'hDEADBEEF, 32'hDEADBEEF, 160, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
